// File: rtl/ripple_sub4.sv
// Registered WIDTH-bit ripple-borrow subtractor, diff = (a - b) mod 2^WIDTH, built from gate primitives.
// Define SUB4_BORROW_OUT_EN to add a registered borrow_out port (1 iff a < b).
module ripple_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SUB4_BORROW_OUT_EN
  output logic             borrow_out,
`endif
  output logic [WIDTH-1:0] diff
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] d_vec;
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] diff_q;

  assign bin[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic ab_x;
    xor u_x_ab (ab_x, a[i], b[i]);
    xor u_x_d  (d_vec[i], ab_x, bin[i]);

    // The last cell's borrow only exists when something reads it.
    if (i < WIDTH - 1) begin : g_borrow
      logic a_n, ab_xn, t_gen, t_prop;
      not u_n_a  (a_n, a[i]);
      not u_n_x  (ab_xn, ab_x);
      and u_a_g  (t_gen, a_n, b[i]);
      and u_a_p  (t_prop, ab_xn, bin[i]);
      or  u_o_b  (bin[i+1], t_gen, t_prop);
    end
  end

`ifdef SUB4_BORROW_OUT_EN
  logic final_borrow;
  logic borrow_d;
  logic borrow_q;
  logic last_a_n, last_xn, last_gen, last_prop;

  not u_last_n_a (last_a_n, a[WIDTH-1]);
  not u_last_n_x (last_xn, g_cell[WIDTH-1].ab_x);
  and u_last_g   (last_gen, last_a_n, b[WIDTH-1]);
  and u_last_p   (last_prop, last_xn, bin[WIDTH-1]);
  or  u_last_o   (final_borrow, last_gen, last_prop);

  always_comb begin
    borrow_d = rst ? 1'b0 : final_borrow;
  end

  always_ff @(posedge clk) begin
    borrow_q <= borrow_d;
  end

  assign borrow_out = borrow_q;
`endif

  // NOTE: reset is synchronous, so it is folded into the next-state value rather than the sensitivity list.
  always_comb begin
    diff_d = rst ? '0 : d_vec;
  end

  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    diff_q <= diff_d;
  end

  assign diff = diff_q;

endmodule

// File: tb/tb_ripple_sub4.sv
// Self-checking bench for ripple_sub4: directed boundaries, exhaustive sweeps, random operands, mid-sweep reset.
module tb_ripple_sub4;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
`ifdef SUB4_BORROW_OUT_EN
  logic             borrow_out;
`endif

  int checks   = 0;
  int failures = 0;

  ripple_sub4 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
`ifdef SUB4_BORROW_OUT_EN
    .borrow_out (borrow_out),
`endif
    .diff       (diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned operands, wrapped into WIDTH bits.
  function automatic int model_diff(input int ua, input int ub, input bit r);
    int m;
    m = 1 << WIDTH;
    return r ? 0 : ((ua - ub) % m + m) % m;
  endfunction

  function automatic int model_borrow(input int ua, input int ub, input bit r);
    return (!r && ua < ub) ? 1 : 0;
  endfunction

  // Drive operands, take one edge, then check the registered result after the edge settles.
  task automatic apply(input int ta, input int tb_v, input bit tr, input string tag);
    a   = ta[WIDTH-1:0];
    b   = tb_v[WIDTH-1:0];
    rst = tr;
    @(posedge clk);
    #1;
    check(tag, 32'(diff), 32'(model_diff(ta, tb_v, tr)));
`ifdef SUB4_BORROW_OUT_EN
    check({tag, "_borrow"}, 32'(borrow_out), 32'(model_borrow(ta, tb_v, tr)));
`endif
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;
    @(negedge clk);

    apply(9, 3, 1'b1, "reset_edge1");
    apply(9, 3, 1'b1, "reset_edge2");
    apply(9, 3, 1'b0, "first_result");
    @(negedge clk);
    check("hold_value", 32'(diff), 32'd6);

    apply(3, 5, 1'b0, "wrap_3_minus_5");
    apply(0, 15, 1'b0, "zero_minus_15");
    apply(0, 1, 1'b0, "zero_minus_1");
    apply(7, 7, 1'b0, "equal_operands");
    apply(15, 0, 1'b0, "max_minus_zero");

    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 256; i++) begin
        if (pass == 1 && i == 100) begin
          apply(i / 16, i % 16, 1'b1, "mid_sweep_reset");
        end else begin
          apply(i / 16, i % 16, 1'b0, "sweep");
        end
      end
    end

    for (int k = 0; k < 200; k++) begin
      int ra, rb;
      ra = int'($urandom_range(0, (1 << WIDTH) - 1));
      rb = int'($urandom_range(0, (1 << WIDTH) - 1));
      apply(ra, rb, ($urandom_range(0, 19) == 0), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
